// File: rtl/lf_pkg.sv
// Shared types and helpers for the Ladner-Fischer adder prefix stages.
package lf_pkg;

  localparam int LF_W   = 32;
  localparam int LF_GRP = LF_W / 2;

  // Propagate/generate pair for a single bit or a merged group
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // One beat leaving the first prefix level
  typedef struct packed {
    logic [LF_GRP-1:0] p_list1;
    logic [LF_GRP-1:0] g_list1;
    logic [LF_W-1:0]   p_bit;
  } lvl1_beat_t;

  // Black cell: merges a higher-order group onto the adjacent lower-order one
  function automatic pg_t black_cell(input pg_t hi, input pg_t lo);
    pg_t res;
    res.p = hi.p & lo.p;
    res.g = hi.g | (hi.p & lo.g);
    return res;
  endfunction

endpackage

// File: rtl/lf_skid_buf.sv
// Two-entry valid/ready skid buffer over lvl1_beat_t. in_ready is a register,
// so the upstream handshake never sees a combinational path from out_ready.
module lf_skid_buf
  import lf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  lvl1_beat_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output lvl1_beat_t out_data
);

  logic       vld_p1;
  logic       skid_vld_p1;
  logic       rdy_p1;
  lvl1_beat_t main_p1;
  lvl1_beat_t skid_p1;

  logic accept;
  logic consume;
  logic load_main;
  logic load_skid;
  logic skid_vld_nxt;

  // Transfer decisions: main refills whenever it is empty or being drained
  always_comb begin
    accept       = in_valid && rdy_p1;
    consume      = vld_p1 && out_ready;
    load_main    = consume || !vld_p1;
    load_skid    = accept && !load_main;
    skid_vld_nxt = skid_vld_p1;
    if (load_skid) begin
      skid_vld_nxt = 1'b1;
    end else if (load_main) begin
      skid_vld_nxt = 1'b0;
    end
  end

  // Control state: valids and the registered ready, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b1;
    end else begin
      if (load_main) begin
        vld_p1 <= skid_vld_p1 || accept;
      end
      skid_vld_p1 <= skid_vld_nxt;
      rdy_p1      <= !skid_vld_nxt;
    end
  end

  // Data storage: skid contents have priority over a new beat to keep FIFO order
  always_ff @(posedge clk) begin
    if (load_main) begin
      main_p1 <= skid_vld_p1 ? skid_p1 : in_data;
    end
    if (load_skid) begin
      skid_p1 <= in_data;
    end
  end

  assign in_ready  = rdy_p1;
  assign out_valid = vld_p1;
  assign out_data  = main_p1;

endmodule

// File: rtl/level1_pipe.sv
// First registered prefix level of the 32-bit Ladner-Fischer adder.
// Forms per-bit P/G, merges bit pairs with black cells into W/2 groups,
// and registers the result behind a 2-entry skid buffer.
// Optional macro CARRY_IN_EN adds a cin port folded into g[0].
module level1_pipe
  import lf_pkg::*;
#(
  parameter int W = LF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef CARRY_IN_EN
  input  logic           cin,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W/2-1:0] p_list1,
  output logic [W/2-1:0] g_list1,
  output logic [W-1:0]   p_bit
);

  pg_t        bit_pg [W];
  pg_t        merged;
  lvl1_beat_t beat_p0;
  lvl1_beat_t beat_p1;
  logic       vld_p1;

  // Stage p0: per-bit propagate/generate, carry-in folded into bit 0
  always_comb begin
    for (int i = 0; i < W; i++) begin
      bit_pg[i].p = a[i] ^ b[i];
      bit_pg[i].g = a[i] & b[i];
    end
`ifdef CARRY_IN_EN
    bit_pg[0].g = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
`endif
  end

  // Stage p0: black-cell merge of each adjacent bit pair into one group
  always_comb begin
    beat_p0       = '0;
    merged        = '0;
    beat_p0.p_bit = a ^ b;
    for (int n = 0; n < W / 2; n++) begin
      merged             = black_cell(bit_pg[2*n+1], bit_pg[2*n]);
      beat_p0.p_list1[n] = merged.p;
      beat_p0.g_list1[n] = merged.g;
    end
  end

  // Stage p0 -> p1 boundary: registered handshake with skid storage
  lf_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (beat_p0),
    .out_valid (vld_p1),
    .out_ready (out_ready),
    .out_data  (beat_p1)
  );

  // Data registers are not reset, so outputs read as zero whenever no beat is held
  always_comb begin
    out_valid = vld_p1;
    p_list1   = vld_p1 ? beat_p1.p_list1 : '0;
    g_list1   = vld_p1 ? beat_p1.g_list1 : '0;
    p_bit     = vld_p1 ? beat_p1.p_bit   : '0;
  end

endmodule

// File: doc/level1_pipe.md
Name: level1_pipe

Overview:
- Registered first prefix stage of the 32-bit Ladner-Fischer adder. It sits directly upstream of level2.
- Takes operands a/b, forms per-bit propagate/generate, and merges adjacent bit pairs with black-cell logic into 16 group P/G pairs, which feed level2 p_list1/g_list1.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the adder can be pipelined under backpressure.

Parameters:
- W, 32, operand width; must be even. Output group width is W/2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage can accept a beat.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in; present only with CARRY_IN_EN.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the beat.
- p_list1  output  W/2  group propagate, feeds level2.
- g_list1  output  W/2  group generate, feeds level2.
- p_bit  output  W  per-bit a^b, forwarded for the final sum XOR.

Behaviour:
- Per-bit logic: p[i]=a[i]^b[i] and g[i]=a[i]&b[i].
- Group n (0..W/2-1) uses hi=2n+1 and lo=2n:
  - p_list1[n]=p[hi]&p[lo]
  - g_list1[n]=g[hi]|(p[hi]&g[lo])
- Transfer rules: an input beat is accepted when in_valid&&in_ready; an output beat is consumed when out_valid&&out_ready.
- Latency is 1 cycle: a beat accepted at edge k is visible on the outputs after edge k, when the main register is free.
- Storage:
  - Main output register (out_*).
  - One skid register. It is loaded only when a beat is accepted while main is valid and not consumed.
- in_ready is registered and equals !skid_valid. It does not depend combinationally on out_ready.
- Simultaneous events:
  - Accept and consume in the same cycle with skid empty: main reloads from the new beat.
  - Consume with skid full: main takes the skid contents, skid empties, and in_ready rises the next cycle.
- Ordering: strict FIFO; no beat may be dropped or duplicated.
- Full condition: main and skid both valid means in_ready=0. in_valid is ignored while in_ready=0.
- Data stability: while out_valid=1 and out_ready=0, all out_* are held stable.
- Reset values (rst=1 at an edge):
  - out_valid=0, in_ready=1 after the edge.
  - p_list1, g_list1 and p_bit = 0.
  - skid_valid=0.
- Reset mid-operation discards all in-flight beats. Inputs are ignored during the cycle rst is high.
- Datapath registers may stay un-reset only if the outputs are masked to 0. The bench checks 0 after reset.

Optional Feature:
- Macro CARRY_IN_EN.
- Defined:
  - The cin port exists and is captured with the operands.
  - g[0] becomes (a[0]&b[0])|((a[0]^b[0])&cin), so g_list1[0] includes the carry-in.
  - p_bit is unchanged.
- Undefined:
  - No cin port; g[0]=a[0]&b[0].
  - The downstream sum assumes a carry-in of 0.

Decomposition:
- Shared package lf_pkg holds:
  - Constant LF_W=32 and LF_GRP=LF_W/2.
  - Typedef pg_t {p,g}.
  - Typedef lvl1_beat_t {p_list1, g_list1, p_bit}, used for both the main and skid registers.
- The existing black cell is reused for the W/2 pair merges.
- One natural sub-module, lf_skid_buf: a generic 2-entry valid/ready skid buffer over lvl1_beat_t.

Test Plan:
- a=0x00000003, b=0x00000001, out_ready=1 -> next cycle out_valid=1, p_list1=0x0000, g_list1=0x0001, p_bit=0x00000002.
- a=0xFFFFFFFF, b=0x00000000 -> p_list1=0xFFFF, g_list1=0x0000; a=b=0xFFFFFFFF -> p_list1=0x0000, g_list1=0xFFFF, p_bit=0.
- CARRY_IN_EN defined, a=0x00000003, b=0, cin=1 -> p_list1=0x0001, g_list1=0x0001; same input with the macro undefined -> g_list1=0x0000.
- Backpressure:
  - Stimulus: stream beats 1..6 with in_valid held high; hold out_ready=0 for 3 cycles after the first accept, then set out_ready=1.
  - Required: exactly 2 beats accepted, and in_ready=0 from the cycle after the second accept.
  - Required: out_* stable while stalled.
  - Required: after release, beats emerge in order 1..6 with no gaps or duplicates.
- Reset while main and skid are full -> after the reset edge out_valid=0, in_ready=1, outputs 0; the next beat after rst deasserts is the first output.
- Random soak of 10k beats with random in_valid/out_ready -> a scoreboard matches a golden pair-merge model with zero drops or reorders.
